// File: rtl/sobol_pkg.sv
// Shared constants, types and direction-vector helper for the Sobol RNG arbiter.
package sobol_pkg;

   localparam int INWD_DEF = 6;
   localparam int NREQ_DEF = 4;

   typedef logic [INWD_DEF-1:0] rnd_t;

   // First-dimension Sobol direction number for bit k of a w-bit generator.
   function automatic logic [31:0] sobol_dir(input int k, input int w);
      return 32'd1 << (w - 1 - k);
   endfunction

endpackage

// File: rtl/sobol_rng_core.sv
// Gray-code Sobol generator: counter, least-significant-zero detect and state XOR.
module sobol_rng_core
   import sobol_pkg::*;
#(
   parameter int INWD = INWD_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr,
   input  logic            step,
   output logic [INWD-1:0] rnd,
   output logic            last
);

   logic [INWD-1:0] cnt_q, cnt_d;
   logic [INWD-1:0] s_q, s_d;
   logic [31:0]     dir;
   int              k;

   always_comb begin
      // All-ones counter falls through to the MSB, which steers s back to 0.
      k = INWD - 1;
      for (int i = INWD - 1; i >= 0; i--) begin
         if (!cnt_q[i]) k = i;
      end
      dir   = sobol_dir(k, INWD);
      cnt_d = cnt_q;
      s_d   = s_q;
      if (clr) begin
         cnt_d = '0;
         s_d   = '0;
      end else if (step) begin
         cnt_d = cnt_q + INWD'(1);
         s_d   = s_q ^ dir[INWD-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         s_q   <= '0;
      end else begin
         cnt_q <= cnt_d;
         s_q   <= s_d;
      end
   end

   assign rnd  = s_q;
   assign last = &cnt_q;

endmodule

// File: rtl/sobol_rng_arbiter.sv
// Round-robin arbiter handing out values from one shared Sobol generator.
// Optional output rnd_last enabled by macro SOBOL_ARB_LAST_FLAG_EN.
module sobol_rng_arbiter
   import sobol_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int INWD = INWD_DEF,
   localparam int PW  = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] gnt,
   output logic            rnd_valid,
   output logic [INWD-1:0] rnd,
   output logic [PW-1:0]   rnd_owner
`ifdef SOBOL_ARB_LAST_FLAG_EN
   ,
   output logic            rnd_last
`endif
);

   logic [NREQ-1:0] gnt_q, gnt_d;
   logic            valid_q, valid_d;
   logic [INWD-1:0] rnd_q, rnd_d;
   logic [PW-1:0]   owner_q, owner_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic            last_q, last_d;
   logic            found;
   logic            step;
   int              cand;
   int              idx;
   logic [INWD-1:0] core_rnd;
   logic            core_last;

   sobol_rng_core #(.INWD(INWD)) u_core (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .step  (step),
      .rnd   (core_rnd),
      .last  (core_last)
   );

   always_comb begin
      found = 1'b0;
      idx   = 0;
      cand  = 0;
      for (int off = 0; off < NREQ; off++) begin
         cand = (int'(ptr_q) + off) % NREQ;
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

   assign step = found && !clr;

   always_comb begin
      gnt_d   = '0;
      valid_d = 1'b0;
      rnd_d   = rnd_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      last_d  = 1'b0;
      if (clr) begin
         ptr_d = '0;
      end else if (found) begin
         gnt_d[idx] = 1'b1;
         valid_d    = 1'b1;
         rnd_d      = core_rnd;
         owner_d    = PW'(idx);
         ptr_d      = PW'((idx + 1) % NREQ);
         last_d     = core_last;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_q   <= '0;
         valid_q <= 1'b0;
         rnd_q   <= '0;
         owner_q <= '0;
         ptr_q   <= '0;
         last_q  <= 1'b0;
      end else begin
         gnt_q   <= gnt_d;
         valid_q <= valid_d;
         rnd_q   <= rnd_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         last_q  <= last_d;
      end
   end

   assign gnt       = gnt_q;
   assign rnd_valid = valid_q;
   assign rnd       = rnd_q;
   assign rnd_owner = owner_q;

`ifdef SOBOL_ARB_LAST_FLAG_EN
   assign rnd_last = last_q;
`else
   logic unused_last;
   assign unused_last = last_q;
`endif

endmodule

// File: tb/tb_sobol_rng_arbiter.sv
// Directed self-checking bench for sobol_rng_arbiter (NREQ=4, INWD=6).
module tb_sobol_rng_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clr = 1'b0;
   logic [3:0] req = 4'b0;
   logic [3:0] gnt;
   logic       rnd_valid;
   logic [5:0] rnd;
   logic [1:0] rnd_owner;
`ifdef SOBOL_ARB_LAST_FLAG_EN
   logic       rnd_last;
`endif

   int checks = 0;
   int passed = 0;

   int seq8 [8] = '{0, 32, 48, 16, 24, 56, 40, 8};

   sobol_rng_arbiter #(.NREQ(4), .INWD(6)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .req       (req),
      .gnt       (gnt),
      .rnd_valid (rnd_valid),
      .rnd       (rnd),
      .rnd_owner (rnd_owner)
`ifdef SOBOL_ARB_LAST_FLAG_EN
      ,
      .rnd_last  (rnd_last)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic restart();
      req = 4'b0;
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++;
      if (gnt !== 4'b0 || rnd_valid !== 1'b0 || rnd !== 6'd0 || rnd_owner !== 2'd0)
         $display("FAIL reset: gnt=%b valid=%b rnd=%0d owner=%0d required 0000/0/0/0",
                  gnt, rnd_valid, rnd, rnd_owner);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      req = 4'b0001;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (gnt !== 4'b0001 || rnd_valid !== 1'b1 || rnd !== 6'(seq8[i]))
            $display("FAIL single[%0d]: gnt=%b valid=%b rnd=%0d required 0001/1/%0d",
                     i, gnt, rnd_valid, rnd, seq8[i]);
         else passed++;
      end
      req = 4'b0;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      checks++;
      if (gnt !== 4'b0 || rnd_valid !== 1'b0 || rnd !== 6'd8)
         $display("FAIL clr_hold: gnt=%b valid=%b rnd=%0d required 0000/0/8", gnt, rnd_valid, rnd);
      else passed++;
   endtask

   task automatic test_round_robin();
      logic [3:0] eg [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [3:0] eg2 [3] = '{4'b0010, 4'b1000, 4'b0010};
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (gnt !== eg[i] || rnd_owner !== 2'(i % 4) || rnd !== 6'(seq8[i]) || rnd_valid !== 1'b1)
            $display("FAIL rr[%0d]: gnt=%b owner=%0d rnd=%0d required %b/%0d/%0d",
                     i, gnt, rnd_owner, rnd, eg[i], i % 4, seq8[i]);
         else passed++;
      end
      restart();
      req = 4'b1010;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (gnt !== eg2[i] || rnd !== 6'(seq8[i]))
            $display("FAIL rr_skip[%0d]: gnt=%b rnd=%0d required %b/%0d", i, gnt, rnd, eg2[i], seq8[i]);
         else passed++;
      end
      restart();
   endtask

   task automatic test_period();
      logic [63:0] seen = '0;
      int          dup = 0;
      req = 4'b0001;
      for (int i = 0; i < 64; i++) begin
         tick();
         checks++;
         if (gnt !== 4'b0001 || rnd_valid !== 1'b1)
            $display("FAIL period_gnt[%0d]: gnt=%b valid=%b required 0001/1", i, gnt, rnd_valid);
         else passed++;
         if (seen[rnd]) dup++;
         seen[rnd] = 1'b1;
`ifdef SOBOL_ARB_LAST_FLAG_EN
         checks++;
         if (rnd_last !== (i == 63))
            $display("FAIL period_last[%0d]: rnd_last=%b required %b", i, rnd_last, i == 63);
         else passed++;
`endif
      end
      checks++;
      if (seen !== {64{1'b1}} || dup != 0)
         $display("FAIL period_cover: seen=%h dups=%0d required all ones/0", seen, dup);
      else passed++;
      tick();
      checks++;
      if (rnd !== 6'd0 || gnt !== 4'b0001)
         $display("FAIL period_wrap: rnd=%0d gnt=%b required 0/0001", rnd, gnt);
      else passed++;
`ifdef SOBOL_ARB_LAST_FLAG_EN
      checks++;
      if (rnd_last !== 1'b0)
         $display("FAIL period_wrap_last: rnd_last=%b required 0", rnd_last);
      else passed++;
`endif
      restart();
   endtask

   task automatic test_clr();
      req = 4'b0001;
      repeat (5) tick();
      req = 4'b0100;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      checks++;
      if (gnt !== 4'b0 || rnd_valid !== 1'b0 || rnd !== 6'd24)
         $display("FAIL clr_edge: gnt=%b valid=%b rnd=%0d required 0000/0/24", gnt, rnd_valid, rnd);
      else passed++;
      tick();
      checks++;
      if (gnt !== 4'b0100 || rnd !== 6'd0 || rnd_owner !== 2'd2 || rnd_valid !== 1'b1)
         $display("FAIL clr_next: gnt=%b rnd=%0d owner=%0d required 0100/0/2", gnt, rnd, rnd_owner);
      else passed++;
      restart();
   endtask

   task automatic test_idle();
      int bad = 0;
      req = 4'b0001;
      repeat (3) tick();
      req = 4'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (gnt !== 4'b0 || rnd_valid !== 1'b0 || rnd !== 6'd48 || rnd_owner !== 2'd0) bad++;
      end
      checks++;
      if (bad != 0)
         $display("FAIL idle_hold: %0d bad cycles, last gnt=%b valid=%b rnd=%0d required 0 bad (0000/0/48)",
                  bad, gnt, rnd_valid, rnd);
      else passed++;
      req = 4'b0001;
      tick();
      checks++;
      if (rnd !== 6'd16 || gnt !== 4'b0001)
         $display("FAIL idle_resume: rnd=%0d gnt=%b required 16/0001", rnd, gnt);
      else passed++;
   endtask

   task automatic test_async_reset();
      req = 4'b1111;
      repeat (2) tick();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (gnt !== 4'b0 || rnd_valid !== 1'b0 || rnd !== 6'd0 || rnd_owner !== 2'd0)
         $display("FAIL async_reset: gnt=%b valid=%b rnd=%0d owner=%0d required 0000/0/0/0",
                  gnt, rnd_valid, rnd, rnd_owner);
      else passed++;
      req = 4'b0110;
      @(negedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      tick();
      checks++;
      if (gnt !== 4'b0010 || rnd !== 6'd0 || rnd_owner !== 2'd1 || rnd_valid !== 1'b1)
         $display("FAIL after_reset: gnt=%b rnd=%0d owner=%0d required 0010/0/1", gnt, rnd, rnd_owner);
      else passed++;
      req = 4'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_period();
      test_clr();
      test_idle();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
